// File: rtl/pwm_duty_sequencer.sv
// Per-channel PWM duty sequencer: commands select SET/RAMP/BREATHE/HOLD behaviour,
// and each channel's duty advances once per frame_end pulse.
module pwm_duty_sequencer #(
    parameter int unsigned NCH    = 4,
    parameter int unsigned PERIOD = 100,
    parameter int unsigned DW     = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_ch,
    input  logic [1:0]        cmd_mode,
    input  logic [DW-1:0]     cmd_duty,
    input  logic [3:0]        cmd_step,
    input  logic              frame_end,
    output logic [NCH*DW-1:0] duty_out,
    output logic              duty_load,
    output logic [NCH-1:0]    busy,
    output logic [NCH-1:0]    ramp_done
);

    localparam int unsigned XW = DW + 1;
    localparam logic [XW-1:0] PeriodX = XW'(PERIOD);

    localparam logic [1:0] ModeSet     = 2'b00;
    localparam logic [1:0] ModeRamp    = 2'b01;
    localparam logic [1:0] ModeBreathe = 2'b10;
    localparam logic [1:0] ModeHold    = 2'b11;

    typedef enum logic [1:0] {StHold, StRamp, StBrUp, StBrDn} ch_state_e;

    typedef struct packed {
        ch_state_e     state;
        logic [DW-1:0] duty;
        logic          done;
        logic          pend;
    } upd_t;

    ch_state_e     state_q [NCH];
    ch_state_e     state_d [NCH];
    logic [DW-1:0] duty_q  [NCH];
    logic [DW-1:0] duty_d  [NCH];
    logic [DW-1:0] target_q[NCH];
    logic [DW-1:0] target_d[NCH];
    logic [3:0]    step_q  [NCH];
    logic [3:0]    step_d  [NCH];
    // SET only applies its target at the next frame_end; this flags that pending load.
    logic [NCH-1:0] set_pend_q, set_pend_d;
    logic [NCH-1:0] ramp_done_q, ramp_done_d;
    logic           duty_load_q;
    logic           ready_q;

    logic          cmd_acc;
    logic [XW-1:0] cmd_duty_x;
    logic [DW-1:0] cmd_target;
    logic [3:0]    cmd_step_c;

    function automatic upd_t frame_update(input ch_state_e     st,
                                          input logic [DW-1:0] duty,
                                          input logic [DW-1:0] tgt,
                                          input logic [3:0]    step,
                                          input logic          pend);
        logic [XW-1:0] d, t, s, sum, nd;
        upd_t r;
        d   = {1'b0, duty};
        t   = {1'b0, tgt};
        s   = XW'(step);
        sum = d + s;
        nd  = d;
        r.state = st;
        r.done  = 1'b0;
        r.pend  = pend;
        unique case (st)
            StHold: begin
                if (pend) begin
                    nd     = t;
                    r.pend = 1'b0;
                end
            end
            StRamp: begin
                if (d < t) begin
                    nd = (sum >= t) ? t : sum;
                end else if (d > t) begin
                    nd = ((d - t) <= s) ? t : (d - s);
                end
                if (nd == t) begin
                    r.state = StHold;
                    r.done  = 1'b1;
                end
            end
            StBrUp: begin
                nd = (sum >= t) ? t : sum;
                if (nd == t) r.state = StBrDn;
            end
            StBrDn: begin
                nd = (d > s) ? (d - s) : '0;
                if (nd == '0) r.state = StBrUp;
            end
            default: ;
        endcase
        r.duty = nd[DW-1:0];
        return r;
    endfunction

    always_comb begin
        cmd_acc    = cmd_valid & ready_q;
        cmd_duty_x = {1'b0, cmd_duty};
        cmd_target = (cmd_duty_x > PeriodX) ? PeriodX[DW-1:0] : cmd_duty;
        cmd_step_c = (cmd_step == 4'd0) ? 4'd1 : cmd_step;
    end

    // A command landing on a frame_end cycle governs that frame's update.
    always_comb begin
        upd_t r;
        r           = '0;
        ramp_done_d = '0;
        set_pend_d  = set_pend_q;
        for (int unsigned c = 0; c < NCH; c++) begin
            state_d[c]  = state_q[c];
            duty_d[c]   = duty_q[c];
            target_d[c] = target_q[c];
            step_d[c]   = step_q[c];
            if (cmd_acc && (32'(cmd_ch) == c)) begin
                step_d[c] = cmd_step_c;
                unique case (cmd_mode)
                    ModeSet: begin
                        state_d[c]    = StHold;
                        target_d[c]   = cmd_target;
                        set_pend_d[c] = 1'b1;
                    end
                    ModeRamp: begin
                        state_d[c]    = StRamp;
                        target_d[c]   = cmd_target;
                        set_pend_d[c] = 1'b0;
                    end
                    ModeBreathe: begin
                        state_d[c]    = StBrUp;
                        target_d[c]   = cmd_target;
                        set_pend_d[c] = 1'b0;
                    end
                    ModeHold: begin
                        state_d[c]    = StHold;
                        set_pend_d[c] = 1'b0;
                    end
                    default: ;
                endcase
            end
            if (frame_end) begin
                r = frame_update(state_d[c], duty_q[c], target_d[c], step_d[c], set_pend_d[c]);
                state_d[c]     = r.state;
                duty_d[c]      = r.duty;
                set_pend_d[c]  = r.pend;
                ramp_done_d[c] = r.done;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned c = 0; c < NCH; c++) begin
                state_q[c]  <= StHold;
                duty_q[c]   <= '0;
                target_q[c] <= '0;
                step_q[c]   <= 4'd1;
            end
            set_pend_q  <= '0;
            ramp_done_q <= '0;
            duty_load_q <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            for (int unsigned c = 0; c < NCH; c++) begin
                state_q[c]  <= state_d[c];
                duty_q[c]   <= duty_d[c];
                target_q[c] <= target_d[c];
                step_q[c]   <= step_d[c];
            end
            set_pend_q  <= set_pend_d;
            ramp_done_q <= ramp_done_d;
            duty_load_q <= frame_end;
            ready_q     <= 1'b1;
        end
    end

    always_comb begin
        duty_out = '0;
        busy     = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            duty_out[c*DW +: DW] = duty_q[c];
            busy[c]              = (state_q[c] != StHold);
        end
    end

    assign cmd_ready = ready_q;
    assign duty_load = duty_load_q;
    assign ramp_done = ramp_done_q;

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Self-checking bench for pwm_duty_sequencer: expected duty vectors are queued per
// frame_end and compared when duty_load appears.
module tb_pwm_duty_sequencer;

    localparam int NCH    = 4;
    localparam int DW     = 8;
    localparam int PERIOD = 100;

    localparam logic [1:0] ModeSet     = 2'b00;
    localparam logic [1:0] ModeRamp    = 2'b01;
    localparam logic [1:0] ModeBreathe = 2'b10;
    localparam logic [1:0] ModeHold    = 2'b11;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_ch;
    logic [1:0]        cmd_mode;
    logic [DW-1:0]     cmd_duty;
    logic [3:0]        cmd_step;
    logic              frame_end;
    logic [NCH*DW-1:0] duty_out;
    logic              duty_load;
    logic [NCH-1:0]    busy;
    logic [NCH-1:0]    ramp_done;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [NCH*DW-1:0] duty;
        logic [NCH-1:0]    done;
    } exp_t;

    exp_t              sb[$];
    logic [NCH*DW-1:0] exp_vec;

    always #5 clk = ~clk;

    pwm_duty_sequencer #(
        .NCH   (NCH),
        .PERIOD(PERIOD),
        .DW    (DW)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_ch   (cmd_ch),
        .cmd_mode (cmd_mode),
        .cmd_duty (cmd_duty),
        .cmd_step (cmd_step),
        .frame_end(frame_end),
        .duty_out (duty_out),
        .duty_load(duty_load),
        .busy     (busy),
        .ramp_done(ramp_done)
    );

    // Scoreboard monitor: every duty_load pops one expected frame result.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset_n === 1'b1) begin
            if (duty_load === 1'b1) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_load: duty_out=%h with no frame_end pending", duty_out);
                end else begin
                    e = sb.pop_front();
                    if (duty_out !== e.duty || ramp_done !== e.done) begin
                        fails++;
                        $display("FAIL frame_result: duty_out=%h ramp_done=%b, expected %h / %b",
                                 duty_out, ramp_done, e.duty, e.done);
                    end
                end
            end else if (ramp_done !== '0) begin
                tests++;
                fails++;
                $display("FAIL stray_ramp_done: ramp_done=%b without duty_load, expected 0000",
                         ramp_done);
            end
        end
    end

    task automatic send_cmd(input logic [1:0] ch, input logic [1:0] mode,
                            input logic [DW-1:0] duty, input logic [3:0] step);
        cmd_valid = 1'b1;
        cmd_ch    = ch;
        cmd_mode  = mode;
        cmd_duty  = duty;
        cmd_step  = step;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic pulse_frame(input logic [NCH-1:0] done);
        exp_t e;
        e.duty = exp_vec;
        e.done = done;
        sb.push_back(e);
        frame_end = 1'b1;
        @(posedge clk);
        #1;
        frame_end = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 8 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: %0d frame results never arrived, expected 0 pending",
                     name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        cmd_valid = 1'b1;
        cmd_ch    = 2'd0;
        cmd_mode  = ModeSet;
        cmd_duty  = 8'd50;
        cmd_step  = 4'd3;
        frame_end = 1'b1;
        exp_vec   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if (duty_out !== '0) begin
            fails++;
            $display("FAIL reset_duty: got %h, expected 0", duty_out);
        end
        tests++;
        if (cmd_ready !== 1'b0 || duty_load !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready_load: ready=%b load=%b, expected 0/0", cmd_ready, duty_load);
        end
        tests++;
        if (busy !== '0 || ramp_done !== '0) begin
            fails++;
            $display("FAIL reset_busy_done: busy=%b done=%b, expected 0/0", busy, ramp_done);
        end
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        cmd_valid = 1'b0;
        frame_end = 1'b0;
        @(negedge clk);
        tests++;
        if (cmd_ready !== 1'b0) begin
            fails++;
            $display("FAIL ready_before_first_edge: got %b, expected 0", cmd_ready);
        end
        @(negedge clk);
        tests++;
        if (cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL ready_after_release: got %b, expected 1", cmd_ready);
        end
    endtask

    task automatic test_ramp();
        int v[4] = '{5, 10, 15, 20};
        send_cmd(2'd0, ModeRamp, 8'd20, 4'd5);
        @(negedge clk);
        tests++;
        if (busy[0] !== 1'b1 || duty_out !== exp_vec) begin
            fails++;
            $display("FAIL ramp_cmd_only: busy0=%b duty=%h, expected 1 / %h", busy[0], duty_out,
                     exp_vec);
        end
        for (int i = 0; i < 4; i++) begin
            exp_vec[0*DW +: DW] = 8'(v[i]);
            pulse_frame((i == 3) ? 4'b0001 : 4'b0000);
        end
        wait_drain("ramp");
        @(negedge clk);
        tests++;
        if (busy[0] !== 1'b0) begin
            fails++;
            $display("FAIL ramp_busy_after: got %b, expected 0", busy[0]);
        end
    endtask

    task automatic test_ramp_saturate();
        int up[3] = '{5, 10, 12};
        int dn[3] = '{7, 2, 0};
        send_cmd(2'd1, ModeRamp, 8'd12, 4'd5);
        for (int i = 0; i < 3; i++) begin
            exp_vec[1*DW +: DW] = 8'(up[i]);
            pulse_frame((i == 2) ? 4'b0010 : 4'b0000);
        end
        send_cmd(2'd1, ModeRamp, 8'd0, 4'd5);
        for (int i = 0; i < 3; i++) begin
            exp_vec[1*DW +: DW] = 8'(dn[i]);
            pulse_frame((i == 2) ? 4'b0010 : 4'b0000);
        end
        wait_drain("ramp_saturate");
    endtask

    task automatic test_breathe();
        int v[8] = '{4, 8, 10, 6, 2, 0, 4, 8};
        send_cmd(2'd2, ModeBreathe, 8'd10, 4'd4);
        for (int i = 0; i < 8; i++) begin
            exp_vec[2*DW +: DW] = 8'(v[i]);
            pulse_frame(4'b0000);
        end
        wait_drain("breathe");
        tests++;
        if (busy[2] !== 1'b1) begin
            fails++;
            $display("FAIL breathe_busy: got %b, expected 1", busy[2]);
        end
        send_cmd(2'd2, ModeHold, 8'd0, 4'd1);
        @(negedge clk);
        tests++;
        if (busy[2] !== 1'b0) begin
            fails++;
            $display("FAIL hold_busy: got %b, expected 0", busy[2]);
        end
        pulse_frame(4'b0000);
        wait_drain("hold_frozen");
    endtask

    task automatic test_set_clamp_step();
        int v[3] = '{99, 98, 97};
        send_cmd(2'd3, ModeSet, 8'd200, 4'd0);
        @(negedge clk);
        tests++;
        if (duty_out !== exp_vec || busy[3] !== 1'b0) begin
            fails++;
            $display("FAIL set_cmd_only: duty=%h busy3=%b, expected %h / 0", duty_out, busy[3],
                     exp_vec);
        end
        exp_vec[3*DW +: DW] = 8'(PERIOD);
        pulse_frame(4'b0000);
        send_cmd(2'd3, ModeRamp, 8'd97, 4'd0);
        for (int i = 0; i < 3; i++) begin
            exp_vec[3*DW +: DW] = 8'(v[i]);
            pulse_frame((i == 2) ? 4'b1000 : 4'b0000);
        end
        wait_drain("set_clamp_step");
    endtask

    task automatic test_cmd_with_frame();
        int v[3] = '{4, 1, 0};
        exp_t e;
        send_cmd(2'd0, ModeSet, 8'd10, 4'd1);
        exp_vec[0*DW +: DW] = 8'd10;
        pulse_frame(4'b0000);
        exp_vec[0*DW +: DW] = 8'd7;
        e.duty = exp_vec;
        e.done = 4'b0000;
        sb.push_back(e);
        cmd_valid = 1'b1;
        cmd_ch    = 2'd0;
        cmd_mode  = ModeRamp;
        cmd_duty  = 8'd0;
        cmd_step  = 4'd3;
        frame_end = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        frame_end = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_vec[0*DW +: DW] = 8'(v[i]);
            pulse_frame((i == 2) ? 4'b0001 : 4'b0000);
        end
        wait_drain("cmd_with_frame");
    endtask

    task automatic test_multi_done();
        send_cmd(2'd1, ModeRamp, 8'd3, 4'd3);
        send_cmd(2'd3, ModeRamp, 8'd100, 4'd3);
        exp_vec[1*DW +: DW] = 8'd3;
        exp_vec[3*DW +: DW] = 8'd100;
        pulse_frame(4'b1010);
        wait_drain("multi_done");
        tests++;
        if (busy !== 4'b0000) begin
            fails++;
            $display("FAIL multi_busy: got %b, expected 0000", busy);
        end
    endtask

    task automatic test_reset_mid_breathe();
        send_cmd(2'd2, ModeBreathe, 8'd10, 4'd4);
        exp_vec[2*DW +: DW] = 8'd10;
        pulse_frame(4'b0000);
        exp_vec[2*DW +: DW] = 8'd6;
        pulse_frame(4'b0000);
        wait_drain("pre_reset_breathe");
        tests++;
        if (busy[2] !== 1'b1) begin
            fails++;
            $display("FAIL breathe_busy_pre_reset: got %b, expected 1", busy[2]);
        end
        reset_n   = 1'b0;
        frame_end = 1'b1;
        cmd_valid = 1'b1;
        cmd_ch    = 2'd0;
        cmd_mode  = ModeSet;
        cmd_duty  = 8'd50;
        @(negedge clk);
        tests++;
        if (duty_out !== '0 || busy !== '0) begin
            fails++;
            $display("FAIL midreset_duty_busy: duty=%h busy=%b, expected 0/0", duty_out, busy);
        end
        tests++;
        if (cmd_ready !== 1'b0 || duty_load !== 1'b0 || ramp_done !== '0) begin
            fails++;
            $display("FAIL midreset_ctrl: ready=%b load=%b done=%b, expected 0/0/0", cmd_ready,
                     duty_load, ramp_done);
        end
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        frame_end = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL ready_after_midreset: got %b, expected 1", cmd_ready);
        end
        exp_vec = '0;
        pulse_frame(4'b0000);
        pulse_frame(4'b0000);
        wait_drain("post_reset");
    endtask

    initial begin
        cmd_valid = 1'b0;
        cmd_ch    = '0;
        cmd_mode  = '0;
        cmd_duty  = '0;
        cmd_step  = '0;
        frame_end = 1'b0;
        reset_n   = 1'b0;
        test_reset();
        test_ramp();
        test_ramp_saturate();
        test_breathe();
        test_set_clamp_step();
        test_cmd_with_frame();
        test_multi_done();
        test_reset_mid_breathe();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
